muldiv_hilo: RTL and testbench
==============================

MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, HI/LO 32 bits each.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request strobe; sampled on rising edge.
REQ-005 func  input  6  MIPS funct: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
REQ-006 a  input  32  rs operand (multiplicand/dividend/move source).
REQ-007 b  input  32  rt operand (multiplier/divisor).
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle pulse when HI/LO result is committed or a divide-by-zero is flagged.
REQ-010 hi  output  32  HI register; feeds the ALU MFHI path.
REQ-011 lo  output  32  LO register; feeds the ALU MFLO path.
REQ-012 div_zero  output  1  sticky flag, last accepted DIV/DIVU had b == 0.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIX; only IDLE accepts start.
REQ-014 start with busy high SHALL be ignored (no state, flag or operand change).
REQ-015 start in IDLE with func not in REQ-005 list SHALL be ignored.
REQ-016 MTHI/MTLO: hi (resp. lo) <= a at the sampling edge; no busy, no done, state stays IDLE.
REQ-017 Any accepted start SHALL clear div_zero at the sampling edge, except DIV/DIVU with b == 0.
REQ-018 MULT/DIVs: operands converted to 32-bit magnitudes, result sign latched at sampling edge; MULTU/DIVU use raw operands, sign = positive.
REQ-019 MUL: 32 shift-add iterations, one per cycle, into a 64-bit internal accumulator, then FIX.
REQ-020 DIV: 32 restoring-division iterations, one per cycle, then FIX.
REQ-021 FIX (one cycle): apply sign correction, commit to hi/lo, assert done, return to IDLE.
REQ-022 MULT/MULTU result: {hi,lo} = full 64-bit product (two's complement for MULT).
REQ-023 DIV/DIVU result: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0x00000000 (no trap).
REQ-025 Latency: start sampled at edge N -> busy high after N, hi/lo updated and done = 1 after edge N+33, busy low after N+33.
REQ-026 hi/lo SHALL hold previous values during MUL/DIV; only FIX or MTHI/MTLO write them.
REQ-027 DIV/DIVU with b == 0: no iterations; after edge N+1 done = 1, div_zero = 1, busy stays 0, hi/lo unchanged.
REQ-028 done SHALL be high exactly one cycle per completed operation; never with busy.
REQ-029 Back-to-back: start asserted in the cycle done is high SHALL be accepted (state is IDLE then).

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, internal accumulators 0.
REQ-031 Reset mid-operation SHALL abort it with no commit; first start after release is accepted normally.

Verification
REQ-032 MULT a=0xFFFFFFFD (-3), b=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse 1 cycle.
REQ-033 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT same operands -> hi=0, lo=1.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-035 Preload hi=0x11, lo=0x22 via MTHI/MTLO; DIVU a=10, b=0 -> done and div_zero after 1 cycle, hi=0x11, lo=0x22; next MULTU clears div_zero.
REQ-036 MULT in flight, start MTLO at cycle 5 -> ignored, lo unchanged until FIX; reset_n low at cycle 10 -> hi=lo=0, busy=0 immediately, no done.
REQ-037 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; start asserted during done cycle -> second operation accepted.

Source files
------------

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: MIPS-style HI/LO multiply/divide unit.
//   Signed and unsigned 32x32 multiply (shift-add) and divide (restoring),
//   one iteration per clock, 32 iterations followed by one sign-fix cycle.
//   Also implements MTHI/MTLO, which write HI/LO directly from operand a.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   request strobe, sampled on the rising edge
//   func       in   [5:0] MIPS funct code selecting the operation
//   a          in   [31:0] rs operand (multiplicand / dividend / move source)
//   b          in   [31:0] rt operand (multiplier / divisor)
//   busy       out  high while an iterative operation is in progress
//   done       out  one-cycle pulse on commit or on divide-by-zero flagging
//   hi, lo     out  [31:0] architectural HI/LO registers
//   div_zero   out  sticky: the last accepted DIV/DIVU had b == 0
//   fsm_state  out  [1:0] current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 FIX)
//
// Handshake: a request is taken when start is high on a rising edge while
// busy is low (state IDLE); any start seen while busy is high is dropped
// without side effects. Completion is signalled by the one-cycle done pulse,
// which coincides with the first IDLE cycle, so a new start may be issued in
// the same cycle that done is high.

module muldiv_hilo (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [5:0]  func,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_zero,
   output logic [1:0]  fsm_state
);

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t      state, state_nxt;

   // acc holds {partial product, remaining multiplier} for MUL and
   // {partial remainder, dividend-shifting-into-quotient} for DIV.
   logic [63:0] acc;
   logic [31:0] opnd;      // multiplicand or divisor magnitude
   logic [4:0]  cnt;
   logic        is_div;
   logic        neg_lo;    // negate product / quotient at FIX
   logic        neg_hi;    // negate product / remainder at FIX
   logic        dz_pend;   // divide-by-zero: done pulses one cycle later

   logic        op_mul, op_div, op_signed;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum;
   logic [32:0] rem_sh, div_diff;
   logic [63:0] prod_fix;
   logic [31:0] q_fix, r_fix;

   // Operand decode and magnitude conversion
   always_comb begin
      op_mul    = (func == F_MULT) || (func == F_MULTU);
      op_div    = (func == F_DIV)  || (func == F_DIVU);
      op_signed = (func == F_MULT) || (func == F_DIV);
      mag_a     = (op_signed && a[31]) ? -a : a;
      mag_b     = (op_signed && b[31]) ? -b : b;
   end

   // One iteration step for each algorithm plus the final sign fix
   always_comb begin
      mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      rem_sh   = {acc[63:32], acc[31]};
      // bit 32 set means the trial subtraction went negative: restore
      div_diff = rem_sh - {1'b0, opnd};
      prod_fix = neg_hi ? -acc : acc;
      q_fix    = neg_lo ? -acc[31:0]  : acc[31:0];
      r_fix    = neg_hi ? -acc[63:32] : acc[63:32];
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start && op_mul)                    state_nxt = S_MUL;
            else if (start && op_div && (b != '0))  state_nxt = S_DIV;
         end
         S_MUL, S_DIV: if (cnt == 5'd31) state_nxt = S_FIX;
         S_FIX:        state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy      = (state != S_IDLE);
      fsm_state = state;
   end

   // Datapath and architectural registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= '0;
         opnd     <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         dz_pend  <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         done    <= dz_pend;
         dz_pend <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (func)
                     F_MTHI: begin
                        hi       <= a;
                        div_zero <= 1'b0;
                     end
                     F_MTLO: begin
                        lo       <= a;
                        div_zero <= 1'b0;
                     end
                     F_MULT, F_MULTU: begin
                        acc      <= {32'd0, mag_b};
                        opnd     <= mag_a;
                        neg_hi   <= op_signed && (a[31] ^ b[31]);
                        neg_lo   <= op_signed && (a[31] ^ b[31]);
                        is_div   <= 1'b0;
                        cnt      <= '0;
                        div_zero <= 1'b0;
                     end
                     F_DIV, F_DIVU: begin
                        if (b == '0) begin
                           div_zero <= 1'b1;
                           dz_pend  <= 1'b1;
                        end else begin
                           acc      <= {32'd0, mag_a};
                           opnd     <= mag_b;
                           neg_lo   <= op_signed && (a[31] ^ b[31]);
                           neg_hi   <= op_signed && a[31];
                           is_div   <= 1'b1;
                           cnt      <= '0;
                           div_zero <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               acc <= {mul_sum, acc[31:1]};
               cnt <= cnt + 5'd1;
            end
            S_DIV: begin
               if (!div_diff[32]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
               else               acc <= {rem_sh[31:0],   acc[30:0], 1'b0};
               cnt <= cnt + 5'd1;
            end
            S_FIX: begin
               if (is_div) begin
                  lo <= q_fix;
                  hi <= r_fix;
               end else begin
                  hi <= prod_fix[63:32];
                  lo <= prod_fix[31:0];
               end
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: randomized + directed bench for muldiv_hilo.
//   A driver issues requests; a reference model computes the expected
//   HI/LO/div_zero and completion cycle with plain integer arithmetic and
//   pushes it to a scoreboard queue. A monitor on the falling edge pops and
//   compares whenever done is seen, and tracks the architecturally visible
//   HI/LO/div_zero/busy every cycle.

module tb_muldiv_hilo;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start = 1'b0;
   logic [5:0]  func = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;
   logic [1:0]  fsm_state;

   muldiv_hilo dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .func      (func),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .div_zero  (div_zero),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset block ----------------
   initial forever #5 clk = ~clk;

   int cyc = 0;   // number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [63:0] exp_q[$];      // {hi, lo} expected at done
   logic        exp_dz_q[$];
   int          exp_cyc_q[$];  // edge count at which done must appear
   logic [31:0] vis_hi = '0, vis_lo = '0;
   logic        vis_dz = 1'b0;
   int          busy_lo = 0, busy_hi = -1, accept_after = -1;
   int          n_checks = 0, n_fail = 0;
   bit          in_reset = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      if (sgn) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      return {32'd0, x} * {32'd0, y};
   endfunction

   // returns {remainder, quotient}; 64-bit signed math avoids the
   // 0x80000000 / -1 overflow and C-style truncation gives the sign rules
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      logic [63:0] q64, r64;
      if (sgn) begin
         sx  = longint'($signed(x));
         sy  = longint'($signed(y));
         q64 = 64'(sx / sy);
         r64 = 64'(sx % sy);
         return {r64[31:0], q64[31:0]};
      end
      return {x % y, x / y};
   endfunction

   // Called just after the sampling edge; cyc is that edge's number.
   task automatic model_sample(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      if (cyc <= accept_after) return;   // unit busy: request dropped
      case (f)
         F_MTHI: begin vis_hi = x; vis_dz = 1'b0; end
         F_MTLO: begin vis_lo = x; vis_dz = 1'b0; end
         F_MULT, F_MULTU: begin
            exp_q.push_back(ref_mul(f == F_MULT, x, y));
            exp_dz_q.push_back(1'b0);
            exp_cyc_q.push_back(cyc + 33);
            vis_dz = 1'b0;
            busy_lo = cyc; busy_hi = cyc + 32; accept_after = cyc + 33;
         end
         F_DIV, F_DIVU: begin
            if (y == 0) begin
               exp_q.push_back({vis_hi, vis_lo});
               exp_dz_q.push_back(1'b1);
               exp_cyc_q.push_back(cyc + 1);
               vis_dz = 1'b1;
            end else begin
               exp_q.push_back(ref_div(f == F_DIV, x, y));
               exp_dz_q.push_back(1'b0);
               exp_cyc_q.push_back(cyc + 33);
               vis_dz = 1'b0;
               busy_lo = cyc; busy_hi = cyc + 32; accept_after = cyc + 33;
            end
         end
         default: ;
      endcase
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (reset_n && !in_reset) begin
         logic [63:0] e;
         if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
            n_checks++; n_fail++;
            $display("FAIL done_missing at cycle %0d: got no done expected done at cycle %0d", cyc, exp_cyc_q[0]);
            e = exp_q.pop_front();
            void'(exp_dz_q.pop_front());
            void'(exp_cyc_q.pop_front());
            vis_hi = e[63:32]; vis_lo = e[31:0];
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               check("done_unexpected", 64'(done), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
               check("result_hi", 64'(hi), 64'(e[63:32]));
               check("result_lo", 64'(lo), 64'(e[31:0]));
               check("result_div_zero", 64'(div_zero), 64'(exp_dz_q.pop_front()));
               vis_hi = e[63:32]; vis_lo = e[31:0];
            end
         end
         check("hi_visible", 64'(hi), 64'(vis_hi));
         check("lo_visible", 64'(lo), 64'(vis_lo));
         check("div_zero_visible", 64'(div_zero), 64'(vis_dz));
         check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
         check("done_with_busy", 64'(done & busy), 64'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; func = f; a = x; b = y;
      @(posedge clk);
      #1;
      model_sample(f, x, y);
      start = 1'b0;
   endtask

   task automatic idle_until(input int target);
      for (int i = 0; i < 200 && cyc < target; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0 && cyc >= accept_after) break;
         @(negedge clk);
      end
      #1;
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic clear_model();
      exp_q.delete(); exp_dz_q.delete(); exp_cyc_q.delete();
      vis_hi = '0; vis_lo = '0; vis_dz = 1'b0;
      busy_lo = 0; busy_hi = -1; accept_after = -1;
   endtask

   task automatic reset_mid_cycle();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      in_reset = 1'b1;
      #1;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_div_zero", 64'(div_zero), 64'd0);
      clear_model();
      repeat (2) @(negedge clk);
      #2;
      reset_n = 1'b1;
      in_reset = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   logic [5:0] func_tab[8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, 6'b000000, 6'b100000};

   initial begin
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("init_hi", 64'(hi), 64'd0);
      check("init_lo", 64'(lo), 64'd0);
      check("init_busy", 64'(busy), 64'd0);
      check("init_done", 64'(done), 64'd0);
      check("init_div_zero", 64'(div_zero), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      in_reset = 1'b0;

      // signed/unsigned multiply corner cases
      drive(F_MULT,  32'hFFFF_FFFD, 32'd5);          wait_idle();
      drive(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_idle();
      drive(F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_idle();

      // divide sign rules
      drive(F_DIV,  32'hFFFF_FFF9, 32'd2);  wait_idle();
      drive(F_DIVU, 32'd7,         32'd2);  wait_idle();

      // preload, divide by zero keeps HI/LO, next op clears div_zero
      drive(F_MTHI, 32'h11, 32'd0);
      drive(F_MTLO, 32'h22, 32'd0);
      drive(F_DIVU, 32'd10, 32'd0);
      repeat (2) @(posedge clk);
      drive(F_MULTU, 32'd3, 32'd4);  wait_idle();

      // request during MULT ignored, then reset aborts with no commit
      drive(F_MULT, 32'h1234_5678, 32'h8765_4321);
      begin
         int n0;
         n0 = cyc;
         idle_until(n0 + 4);
         drive(F_MTLO, 32'hDEAD_BEEF, 32'd0);
         idle_until(n0 + 9);
      end
      reset_mid_cycle();

      // overflow-free most-negative divide, then back-to-back start
      drive(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      idle_until(accept_after);
      drive(F_MULT, 32'h8000_0000, 32'h8000_0000);
      wait_idle();

      // randomized mix, including dropped requests while busy
      for (int i = 0; i < 40; i++) begin
         drive(func_tab[$urandom_range(0, 7)], pick_operand(), pick_operand());
         repeat ($urandom_range(1, 40)) @(posedge clk);
      end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL global_timeout at cycle %0d: got no finish expected finish", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
